cfg_bank_sequencer: RTL

Configuration controller that programs one tile's memory-bank configuration cells through its bitline (bl) and wordline (wl) buses. It accepts configuration data as a valid/ready word stream and assembles one full bitline row from several words. It then drives bl, pulses exactly one wordline, and steps through every row. One instance sits above each tile's concatenated bl/wl configuration ports, in the programming clock domain.

---
 rtl/cfg_bank_sequencer.sv | 77 +++++++
 1 files changed

// File: rtl/cfg_bank_sequencer.sv
// cfg_bank_sequencer: programs a tile's configuration bank row by row over bl/wl.
//   prog_clk, pReset_n       : programming clock, asynchronous active-low reset
//   start, abort             : begin a full pass (IDLE only) / return to IDLE from anywhere
//   cfg_valid, cfg_ready,
//   cfg_data                 : configuration word stream, most significant word of a row first
//   bl, wl                   : bitline row data and one-hot wordline strobe
//   busy, done               : not IDLE / one-cycle end-of-pass pulse
module cfg_bank_sequencer #(
  parameter int BL_WIDTH   = 80,
  parameter int NUM_ROWS   = 80,
  parameter int DATA_WIDTH = 8,
  parameter int SETUP_CYC  = 1,
  parameter int PULSE_CYC  = 2
) (
  input  logic                  prog_clk,
  input  logic                  pReset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  output logic [BL_WIDTH-1:0]   bl,
  output logic [NUM_ROWS-1:0]   wl,
  output logic                  busy,
  output logic                  done
);
  localparam int WPR  = (BL_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int SW   = WPR * DATA_WIDTH;
  localparam int RW   = NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1;
  localparam int TMAX = SETUP_CYC > PULSE_CYC ? SETUP_CYC : PULSE_CYC;
  localparam int CMAX = WPR > TMAX ? WPR : TMAX;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, PULSE, HOLD, DONE} state_t;
  state_t state, nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] cnt;
  logic [SW-1:0] shreg;
  logic hs, drive_bl;
  assign cfg_ready = state == LOAD;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign hs        = cfg_valid & cfg_ready;
  // shreg only shifts in LOAD, so bl is stable from SETUP through HOLD without its own register
  assign drive_bl  = state == SETUP || state == PULSE || state == HOLD;
  assign bl        = drive_bl ? shreg[BL_WIDTH-1:0] : '0;
  // decoded from the state register so wl drops together with an asynchronous reset
  assign wl        = state == PULSE ? NUM_ROWS'(1) << row : '0;
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else
      unique case (state)
        IDLE:    nxt = start ? LOAD : IDLE;
        LOAD:    nxt = hs && cnt == CW'(WPR - 1) ? SETUP : LOAD;
        SETUP:   nxt = cnt == CW'(SETUP_CYC - 1) ? PULSE : SETUP;
        PULSE:   nxt = cnt == CW'(PULSE_CYC - 1) ? HOLD : PULSE;
        HOLD:    nxt = row == RW'(NUM_ROWS - 1) ? DONE : LOAD;
        DONE:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
  end
  // cnt counts accepted words in LOAD and elapsed cycles in SETUP/PULSE; cleared on every state change
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) begin
      cnt   <= '0;
      row   <= '0;
      shreg <= '0;
    end else begin
      cnt <= nxt != state ? '0 : (hs || state == SETUP || state == PULSE) ? cnt + 1'b1 : cnt;
      if (hs) shreg <= SW'({shreg, cfg_data});
      if (state == IDLE && nxt == LOAD) row <= '0;
      else if (state == HOLD && nxt == LOAD) row <= row + 1'b1;
    end
endmodule
